conv_feed_fifo: RTL

- Source-side buffer feeding the 3x3 convolution stage's pull interface: `o_data`/`valid_out`/`fifo_busy` out, `rd_req` in.
- Accepts pixel words from the upstream producer (DMA or previous layer) through a write port.
- Presents the head word show-ahead and pops it when the consumer asserts `rd_req`.
- Counts popped pixels per WIDTH x WIDTH frame and holds the stream at each frame boundary until the next frame is released.

---
 rtl/conv_feed_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/conv_feed_fifo.sv
// Show-ahead pixel FIFO feeding the 3x3 convolution stage, with a per-frame
// pop counter that holds the stream at every WIDTH x WIDTH frame boundary.
module conv_feed_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 7,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  valid_out,
    output logic                  fifo_busy,
    input  logic                  rd_req,
    input  logic                  frame_start,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ovf_err,
    output logic                  unf_err
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int FRAME_PIX = WIDTH * WIDTH;
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

    typedef enum logic {
        ST_HOLD,
        ST_STREAM
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        pix_cnt;
    logic [CNT_W-1:0]        pix_cnt_next;
    logic                    frame_done_next;

    logic [ADDR_WIDTH:0]     wr_ptr;
    logic [ADDR_WIDTH:0]     rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    empty;
    logic                    frame_hold;
    logic                    do_wr;
    logic                    do_rd;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign level      = wr_ptr - rd_ptr;

    assign frame_hold = (state == ST_HOLD);
    assign o_data     = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign valid_out  = ~empty;
    assign fifo_busy  = empty | frame_hold;

    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_req & valid_out & ~fifo_busy;

    // NOTE: storage has no reset; emptiness is tracked by the pointers alone,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates see the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                ovf_err <= 1'b1;
            end
            if (rd_req && fifo_busy) begin
                unf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            pix_cnt    <= pix_cnt_next;
            frame_done <= frame_done_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned and infers a latch.
    always_comb begin
        state_next      = state;
        pix_cnt_next    = pix_cnt;
        frame_done_next = 1'b0;
        unique case (state)
            ST_HOLD: begin
                if (frame_start) begin
                    state_next   = ST_STREAM;
                    pix_cnt_next = '0;
                end
            end
            ST_STREAM: begin
                // frame_start is ignored here, so a coincident last pop wins.
                if (do_rd) begin
                    if (pix_cnt == LAST_PIX) begin
                        state_next      = ST_HOLD;
                        pix_cnt_next    = '0;
                        frame_done_next = 1'b1;
                    end else begin
                        pix_cnt_next = pix_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

endmodule
